// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronised, edge-latched, masked fixed-priority IRQ arbiter for the sequencer.
// Optional macro IRQ_OVERRUN_DETECT_EN adds sticky per-line irq_overrun flags.
module interrupt_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [7:0]         z_bus,
  input  logic               ctrl_irq_masks_wrt,
  input  logic               ctrl_int_ack,
  input  logic               ctrl_clear_all_ints,
  output logic               int_pending,
  output logic [2:0]         int_vector,
  output logic [NUM_IRQ-1:0] irq_masks,
  output logic [NUM_IRQ-1:0] irq_status
`ifdef IRQ_OVERRUN_DETECT_EN
  ,
  output logic [NUM_IRQ-1:0] irq_overrun
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;
  state_t state;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev, edge_det, mask_eff, active, vec_hot, clr;
  logic [2:0] sel;
  logic ack;
  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev;
  // a mask written this cycle already governs this cycle's arbitration
  assign mask_eff = ctrl_irq_masks_wrt ? irq_masks : z_bus[NUM_IRQ-1:0];
  assign active   = irq_status & mask_eff;
  assign vec_hot  = NUM_IRQ'(1) << int_vector;
  assign ack      = ctrl_int_ack && state == S_REQ;
  assign clr      = ctrl_clear_all_ints ? '1 : ack ? vec_hot : '0;
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) sel = 3'(i);
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev       <= '0;
      irq_status <= '0;
      irq_masks  <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev       <= sync_q[SYNC_STAGES-1];
      irq_status <= (irq_status & ~clr) | edge_det;
      if (!ctrl_irq_masks_wrt) irq_masks <= z_bus[NUM_IRQ-1:0];
    end
  // the granted vector stays frozen in S_REQ; no re-arbitration until the request ends
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state       <= S_IDLE;
      int_pending <= 1'b0;
      int_vector  <= '0;
    end else begin
      case (state)
        S_IDLE: if (|active) begin
          int_vector  <= sel;
          state       <= S_REQ;
          int_pending <= 1'b1;
        end
        S_REQ: if (ctrl_int_ack) begin
          state       <= S_GAP;
          int_pending <= 1'b0;
        end else if (ctrl_clear_all_ints || !(|(active & vec_hot))) begin
          state       <= S_IDLE;
          int_pending <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          int_pending <= 1'b0;
        end
      endcase
    end
`ifdef IRQ_OVERRUN_DETECT_EN
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) irq_overrun <= '0;
    else irq_overrun <= ctrl_clear_all_ints ? '0 : irq_overrun | (edge_det & irq_status & ~clr);
`endif
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed scenarios plus randomized traffic checked against a cycle model.
module tb_interrupt_controller;
  localparam int N = 8, S = 2;
  logic clk = 0, arst_n = 0;
  logic [7:0] irq_in = 0, z_bus = 0;
  logic wrt_n = 1, ack = 0, clr_all = 0;
  logic int_pending;
  logic [2:0] int_vector;
  logic [7:0] irq_masks, irq_status;
`ifdef IRQ_OVERRUN_DETECT_EN
  logic [7:0] irq_overrun;
`endif
  int n_chk = 0, n_pass = 0;
  logic [7:0] hist [S+1];
  logic [7:0] m_pend, m_mask, m_ovr;
  int m_phase, m_vec;
  always #5 clk = ~clk;
  interrupt_controller #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .arst_n(arst_n), .irq_in(irq_in), .z_bus(z_bus),
    .ctrl_irq_masks_wrt(wrt_n), .ctrl_int_ack(ack), .ctrl_clear_all_ints(clr_all),
    .int_pending(int_pending), .int_vector(int_vector),
    .irq_masks(irq_masks), .irq_status(irq_status)
`ifdef IRQ_OVERRUN_DETECT_EN
    , .irq_overrun(irq_overrun)
`endif
  );
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    for (int k = 0; k <= S; k++) hist[k] = 0;
    m_pend = 0; m_mask = 0; m_ovr = 0; m_phase = 0; m_vec = 0;
  endtask
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction
  // phase: 0 idle, 1 requesting, 2 one-cycle gap after an ack
  task automatic model_edge();
    logic [7:0] e, meff, act, clrm;
    e = hist[S-1] & ~hist[S];
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = irq_in;
    meff = wrt_n ? m_mask : z_bus;
    act  = m_pend & meff;
    clrm = clr_all ? 8'hFF : (ack && m_phase == 1) ? 8'(1 << m_vec) : 8'h00;
    m_ovr = clr_all ? 8'h00 : m_ovr | (e & m_pend & ~clrm);
    if (m_phase == 0) begin
      if (act != 0) begin m_vec = lowest(act); m_phase = 1; end
    end else if (m_phase == 1) begin
      if (ack) m_phase = 2;
      else if (clr_all || !act[m_vec]) m_phase = 0;
    end else m_phase = 0;
    m_pend = (m_pend & ~clrm) | e;
    if (!wrt_n) m_mask = z_bus;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pending", int_pending, int'(m_phase == 1));
    check("vector", int_vector, m_vec);
    check("masks", irq_masks, m_mask);
    check("status", irq_status, m_pend);
`ifdef IRQ_OVERRUN_DETECT_EN
    check("overrun", irq_overrun, m_ovr);
`endif
  endtask
  task automatic write_mask(input logic [7:0] m);
    wrt_n = 0; z_bus = m; step(); wrt_n = 1; z_bus = $urandom;
  endtask
  task automatic do_ack();
    ack = 1; step(); ack = 0;
  endtask
  task automatic do_clear();
    clr_all = 1; step(); clr_all = 0;
  endtask
  initial begin
    irq_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pending", int_pending, 0);
    check("rst_masks", irq_masks, 0);
    check("rst_status", irq_status, 0);
    check("rst_vector", int_vector, 0);
    @(negedge clk);
    arst_n = 1;
    model_reset();
    repeat (4) step();
    check("post_rst_status", irq_status, 8'hFF);
    check("post_rst_pending", int_pending, 0);
    irq_in = 0;
    do_clear();
    write_mask(8'h01);
    // latency: request appears after the 4th edge that sees the line high
    irq_in[0] = 1;
    repeat (3) step();
    check("lat_edge3", int_pending, 0);
    step();
    check("lat_edge4", int_pending, 1);
    check("lat_vec", int_vector, 0);
    irq_in[0] = 0;
    do_ack();
    check("ack_drop", int_pending, 0);
    check("ack_status0", irq_status[0], 0);
    step();
    check("gap", int_pending, 0);
    // frozen vector: line 5 granted, later line 2 waits
    write_mask(8'hFF);
    irq_in[5] = 1; step();
    irq_in[2] = 1; step();
    irq_in = 0;
    repeat (4) step();
    check("frozen_vec", int_vector, 5);
    check("frozen_pend", int_pending, 1);
    do_ack();
    step();
    check("gap2", int_pending, 0);
    step();
    check("rearb_pend", int_pending, 1);
    check("rearb_vec", int_vector, 2);
    do_ack();
    repeat (2) step();
    // masking off the requested line withdraws the request but keeps status
    irq_in[3] = 1;
    repeat (4) step();
    irq_in[3] = 0;
    check("req3_vec", int_vector, 3);
    write_mask(8'h00);
    step();
    check("masked_drop", int_pending, 0);
    check("masked_status3", irq_status[3], 1);
    write_mask(8'hFF);
    step();
    check("unmask_pend", int_pending, 1);
    check("unmask_vec", int_vector, 3);
    do_ack();
    repeat (2) step();
    // new edge on line 1 coinciding with the ack of line 1
    irq_in[1] = 1;
    repeat (4) step();
    check("req1_vec", int_vector, 1);
    irq_in[1] = 0; step();
    irq_in[1] = 1; step(); step();
    do_ack();
    irq_in[1] = 0;
    check("ack_edge_status1", irq_status[1], 1);
    step();
    step();
    check("rereq1_pend", int_pending, 1);
    check("rereq1_vec", int_vector, 1);
    ack = 1; clr_all = 1; step(); ack = 0; clr_all = 0;
    check("ack_clr_status", irq_status, 0);
    check("ack_clr_pend", int_pending, 0);
    repeat (2) step();
    // two pulses on line 4 without an ack
    irq_in[4] = 1; repeat (2) step();
    irq_in[4] = 0; repeat (2) step();
    irq_in[4] = 1; repeat (2) step();
    irq_in[4] = 0; repeat (3) step();
`ifdef IRQ_OVERRUN_DETECT_EN
    check("overrun4", irq_overrun[4], 1);
    do_clear();
    check("overrun_clr", irq_overrun, 0);
    irq_in[4] = 1; repeat (4) step(); irq_in[4] = 0;
`endif
    check("req4_pend", int_pending, 1);
    // asynchronous reset between edges drops the request immediately
    #1 arst_n = 0;
    #1;
    check("async_drop", int_pending, 0);
    check("async_masks", irq_masks, 0);
    model_reset();
    #1 arst_n = 1;
    repeat (2) step();
    write_mask(8'hFF);
    for (int c = 0; c < 1500; c++) begin
      irq_in  = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      ack     = (m_phase == 1 && $urandom_range(0, 3) == 0) || $urandom_range(0, 31) == 0;
      clr_all = $urandom_range(0, 63) == 0;
      wrt_n   = $urandom_range(0, 15) != 0;
      z_bus   = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
